// File: rtl/timekeeper_if.sv
// rtl/timekeeper_if.sv - Control, load and status signal bundle for the timekeeper.
// Alarm signals exist only when TIMEKEEPER_ALARM_EN is defined.
interface timekeeper_if #(
  parameter int DAY_W = 16
);
  logic             i_en;
  logic             i_mode12;
  logic             i_load;
  logic [4:0]       i_ld_hours;
  logic [5:0]       i_ld_mins;
  logic [5:0]       i_ld_secs;
  logic [4:0]       o_hours;
  logic             o_pm;
  logic [5:0]       o_mins;
  logic [5:0]       o_secs;
  logic [DAY_W-1:0] o_days;
  logic             o_sec_tick;
  logic             o_day_tick;
  logic             o_load_err;
`ifdef TIMEKEEPER_ALARM_EN
  logic             i_alm_set;
  logic [4:0]       i_alm_hours;
  logic [5:0]       i_alm_mins;
  logic             i_alm_arm;
  logic             o_alarm;
`endif

  modport master (
    output i_en, i_mode12, i_load, i_ld_hours, i_ld_mins, i_ld_secs,
    input  o_hours, o_pm, o_mins, o_secs, o_days, o_sec_tick, o_day_tick, o_load_err
`ifdef TIMEKEEPER_ALARM_EN
    , output i_alm_set, i_alm_hours, i_alm_mins, i_alm_arm
    , input  o_alarm
`endif
  );

  modport slave (
    input  i_en, i_mode12, i_load, i_ld_hours, i_ld_mins, i_ld_secs,
    output o_hours, o_pm, o_mins, o_secs, o_days, o_sec_tick, o_day_tick, o_load_err
`ifdef TIMEKEEPER_ALARM_EN
    , input  i_alm_set, i_alm_hours, i_alm_mins, i_alm_arm
    , output o_alarm
`endif
  );
endinterface

// File: rtl/timekeeper.sv
// rtl/timekeeper.sv - Prescaled time-of-day counter with day count, load and 12/24h display.
// Define TIMEKEEPER_ALARM_EN to build the HH:MM alarm compare.
module timekeeper #(
  parameter int CLK_DIV = 1,
  parameter int DAY_W   = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  timekeeper_if.slave bus
);
  localparam int            PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0]    r_presc;
  logic [4:0]       r_hours;
  logic [5:0]       r_mins;
  logic [5:0]       r_secs;
  logic [DAY_W-1:0] r_days;
  logic             r_sec_tick;
  logic             r_day_tick;
  logic             r_load_err;

  logic             w_tick;
  logic             w_ld_ok;
  logic             w_ld_accept;
  logic             w_set_err;
  logic             w_roll;
  logic [4:0]       w_nxt_hours;
  logic [5:0]       w_nxt_mins;
  logic [5:0]       w_nxt_secs;
  logic [4:0]       w_hours_disp;
  logic             w_pm;

  assign w_tick      = bus.i_en && (r_presc == PRESC_LAST);
  assign w_ld_ok     = (bus.i_ld_hours <= 5'd23) && (bus.i_ld_mins <= 6'd59) &&
                       (bus.i_ld_secs <= 6'd59);
  assign w_ld_accept = bus.i_load && w_ld_ok;

  // Time one second ahead with the full carry chain resolved in one cycle.
  always_comb begin
    w_nxt_secs  = r_secs;
    w_nxt_mins  = r_mins;
    w_nxt_hours = r_hours;
    w_roll      = 1'b0;
    if (r_secs == 6'd59) begin
      w_nxt_secs = 6'd0;
      if (r_mins == 6'd59) begin
        w_nxt_mins = 6'd0;
        if (r_hours == 5'd23) begin
          w_nxt_hours = 5'd0;
          w_roll      = 1'b1;
        end else begin
          w_nxt_hours = r_hours + 5'd1;
        end
      end else begin
        w_nxt_mins = r_mins + 6'd1;
      end
    end else begin
      w_nxt_secs = r_secs + 6'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_presc    <= '0;
      r_hours    <= 5'd0;
      r_mins     <= 6'd0;
      r_secs     <= 6'd0;
      r_days     <= '0;
      r_sec_tick <= 1'b0;
      r_day_tick <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_sec_tick <= 1'b0;
      r_day_tick <= 1'b0;
      r_load_err <= (bus.i_load && !w_ld_ok) || w_set_err;
      if (w_ld_accept) begin
        r_presc <= '0;
        r_hours <= bus.i_ld_hours;
        r_mins  <= bus.i_ld_mins;
        r_secs  <= bus.i_ld_secs;
      end else if (w_tick) begin
        r_presc    <= '0;
        r_hours    <= w_nxt_hours;
        r_mins     <= w_nxt_mins;
        r_secs     <= w_nxt_secs;
        r_sec_tick <= 1'b1;
        r_day_tick <= w_roll;
        if (w_roll) r_days <= r_days + DAY_W'(1);
      end else if (bus.i_en) begin
        r_presc <= r_presc + PW'(1);
      end
    end
  end

  // Hour 0 reads as 12 AM, 12 as 12 PM; the stored hour stays 24-hour.
  always_comb begin
    w_hours_disp = r_hours;
    w_pm         = 1'b0;
    if (bus.i_mode12) begin
      w_pm = (r_hours >= 5'd12);
      if (r_hours == 5'd0)       w_hours_disp = 5'd12;
      else if (r_hours > 5'd12)  w_hours_disp = r_hours - 5'd12;
    end
  end

`ifdef TIMEKEEPER_ALARM_EN
  logic [4:0] r_alm_hours;
  logic [5:0] r_alm_mins;
  logic       r_alarm;
  logic       w_alm_ok;
  logic       w_alm_hit;

  assign w_alm_ok  = (bus.i_alm_hours <= 5'd23) && (bus.i_alm_mins <= 6'd59);
  assign w_set_err = bus.i_alm_set && !w_alm_ok;
  // Match against the time about to be written, so a load or tick landing on HH:MM:00 fires.
  assign w_alm_hit = bus.i_alm_arm && (w_ld_accept ?
                     ((bus.i_ld_hours == r_alm_hours) && (bus.i_ld_mins == r_alm_mins) &&
                      (bus.i_ld_secs == 6'd0)) :
                     (w_tick && (w_nxt_hours == r_alm_hours) && (w_nxt_mins == r_alm_mins) &&
                      (w_nxt_secs == 6'd0)));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_alm_hours <= 5'd0;
      r_alm_mins  <= 6'd0;
      r_alarm     <= 1'b0;
    end else begin
      r_alarm <= w_alm_hit;
      if (bus.i_alm_set && w_alm_ok) begin
        r_alm_hours <= bus.i_alm_hours;
        r_alm_mins  <= bus.i_alm_mins;
      end
    end
  end

  assign bus.o_alarm = r_alarm;
`else
  assign w_set_err = 1'b0;
`endif

  assign bus.o_hours    = w_hours_disp;
  assign bus.o_pm       = w_pm;
  assign bus.o_mins     = r_mins;
  assign bus.o_secs     = r_secs;
  assign bus.o_days     = r_days;
  assign bus.o_sec_tick = r_sec_tick;
  assign bus.o_day_tick = r_day_tick;
  assign bus.o_load_err = r_load_err;
endmodule
